wb_serializer_fifo: RTL and testbench

//  Wishbone-slave frame serializer: CPU writes packed frames of SYMS symbols (k-flag + 8 bits each)

---
 rtl/wb_serializer_fifo.sv | 211 +++++++++++++++++++++
 tb/tb_wb_serializer_fifo.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_serializer_fifo.sv
// Wishbone-slave frame serializer. The CPU pushes packed frames of SYMS symbols
// ({k, byte} each) into a frame FIFO. A single-clock FSM pops them and shifts them
// out bit-serially. Each bit is held for DIV+1 clocks, and the bit order is
// selectable per frame.
// Ports:
//   CLK_I, RST_I            clock, synchronous active-high reset
//   CYC_I/STB_I/WE_I        Wishbone cycle, strobe, write enable
//   ADR_I[3:2]              register select: 0 TXDATA, 1 CTRL, 2 STATUS, 3 unmapped
//   DAT_I / DAT_O           write data / read data (0 unless reading a mapped register)
//   ACK_O / ERR_O           combinational acknowledge / error
//   data_o, valid_o, eot_o  serial bit, bit-valid, end-of-frame pulse
module wb_serializer_fifo #(
  parameter int unsigned SYMS       = 3,
  parameter int unsigned SYM_W      = 9,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16,
  parameter logic        IDLE_LVL   = 1'b0
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        ERR_O,
  output logic        data_o,
  output logic        valid_o,
  output logic        eot_o
);

  localparam int unsigned FRAME_W = SYMS * SYM_W;
  localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW      = AW + 1;
  localparam int unsigned CW      = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_W - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e               state_q, state_d;
  logic                 en_q, msb_q, ovf_q;
  logic [DIV_W-1:0]     div_q;
  logic [FRAME_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]        level_q;
  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d, div_lat_q, div_lat_d;
  logic                 msb_lat_q, msb_lat_d;

  logic        req, full, empty, push, pop, flush, ctrl_wr, stat_wr, ovf_set;
  logic        bit_end, start_ok;
  logic [31:0] ctrl_rd, stat_rd;
  logic        unused_bits;

  assign unused_bits = ^{ADR_I[31:4], ADR_I[1:0], DAT_I};

  assign req   = CYC_I & STB_I;
  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);
  assign flush = ctrl_wr & DAT_I[2];

  always_comb begin
    ctrl_rd                 = '0;
    ctrl_rd[0]              = en_q;
    ctrl_rd[1]              = msb_q;
    ctrl_rd[DIV_W+15:16]    = div_q;
    stat_rd                 = '0;
    stat_rd[0]              = (state_q == StShift);
    stat_rd[1]              = empty;
    stat_rd[2]              = full;
    stat_rd[3]              = ovf_q;
    stat_rd[15:8]           = 8'(level_q);
  end

  // Bus decode; full is judged on the registered level, ignoring any same-cycle pop.
  always_comb begin
    ACK_O   = 1'b0;
    ERR_O   = 1'b0;
    DAT_O   = '0;
    push    = 1'b0;
    ctrl_wr = 1'b0;
    stat_wr = 1'b0;
    ovf_set = 1'b0;
    unique case (ADR_I[3:2])
      2'd0: begin
        if (WE_I) begin
          if (full) begin
            ERR_O   = req;
            ovf_set = req;
          end else begin
            ACK_O = req;
            push  = req;
          end
        end else begin
          ERR_O = req;
        end
      end
      2'd1: begin
        ACK_O   = req;
        ctrl_wr = req & WE_I;
        if (req && !WE_I) DAT_O = ctrl_rd;
      end
      2'd2: begin
        ACK_O   = req;
        stat_wr = req & WE_I;
        if (req && !WE_I) DAT_O = stat_rd;
      end
      default: ERR_O = req;
    endcase
  end

  // Serializer FSM. A pop both leaves IDLE and chains frames back-to-back.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    div_lat_d = div_lat_q;
    msb_lat_d = msb_lat_q;
    pop       = 1'b0;
    eot_o     = 1'b0;
    valid_o   = 1'b0;
    data_o    = IDLE_LVL;
    bit_end   = (div_cnt_q == div_lat_q);
    start_ok  = en_q & ~empty;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          pop     = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        valid_o = 1'b1;
        data_o  = msb_lat_q ? shreg_q[FRAME_W-1] : shreg_q[0];
        if (bit_end) begin
          div_cnt_d = '0;
          if (bit_cnt_q == CNT_LAST) begin
            eot_o = 1'b1;
            if (start_ok) pop = 1'b1;
            else          state_d = StIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shreg_d   = msb_lat_q ? (shreg_q << 1) : (shreg_q >> 1);
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (pop) begin
      shreg_d   = mem[rd_ptr_q];
      bit_cnt_d = '0;
      div_cnt_d = '0;
      div_lat_d = div_q;
      msb_lat_d = msb_q;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (push && !flush) mem[wr_ptr_q] <= DAT_I[FRAME_W-1:0];
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q   <= StIdle;
      en_q      <= 1'b0;
      msb_q     <= 1'b0;
      div_q     <= '0;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      div_lat_q <= '0;
      msb_lat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      div_lat_q <= div_lat_d;
      msb_lat_q <= msb_lat_d;
      if (ctrl_wr) begin
        en_q  <= DAT_I[0];
        msb_q <= DAT_I[1];
        div_q <= DAT_I[DIV_W+15:16];
      end
      if (ovf_set)                 ovf_q <= 1'b1;
      else if (stat_wr && DAT_I[3]) ovf_q <= 1'b0;
      // Flush empties the queue but leaves the frame already in the shift register alone.
      if (flush) begin
        rd_ptr_q <= wr_ptr_q;
        level_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (push && !pop)      level_q <= level_q + 1'b1;
        else if (pop && !push) level_q <= level_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_serializer_fifo.sv
module tb_wb_serializer_fifo;
  localparam int   FW   = 27;
  localparam logic IDLE = 1'b0;

  logic        clk = 1'b0;
  logic        RST_I = 1'b1, CYC_I = 1'b0, STB_I = 1'b0, WE_I = 1'b0;
  logic [31:0] ADR_I = '0, DAT_I = '0, DAT_O;
  logic        ACK_O, ERR_O, data_o, valid_o, eot_o;

  always #5 clk = ~clk;

  wb_serializer_fifo dut (
    .CLK_I(clk), .RST_I(RST_I), .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I),
    .ADR_I(ADR_I), .DAT_I(DAT_I), .DAT_O(DAT_O), .ACK_O(ACK_O), .ERR_O(ERR_O),
    .data_o(data_o), .valid_o(valid_o), .eot_o(eot_o)
  );

  int checks = 0, failures = 0;
  bit exp_q[$];
  int exp_eot[$];
  bit obs_q[$];
  int obs_eot[$];
  int runs;
  bit prev_valid;
  bit timed_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: frame bits in the selected order, each repeated div+1 times.
  task automatic model_frame(input logic [FW-1:0] f, input int div, input bit msb);
    bit b;
    for (int i = 0; i < FW; i++) begin
      b = msb ? f[FW-1-i] : f[i];
      for (int r = 0; r <= div; r++) exp_q.push_back(b);
    end
    exp_eot.push_back(exp_q.size());
  endtask

  task automatic sample_cycle();
    if (valid_o) begin
      if (!prev_valid) runs++;
      obs_q.push_back(data_o);
      if (eot_o) obs_eot.push_back(obs_q.size());
    end
    prev_valid = valid_o;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_eot.delete();
    runs = 0;
    prev_valid = 1'b0;
  endtask

  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     output logic ack, output logic err, output logic [31:0] rd);
    @(negedge clk);
    sample_cycle();
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = dat;
    #1;
    ack = ACK_O; err = ERR_O; rd = DAT_O;
    @(posedge clk);
    #1;
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; ADR_I = '0; DAT_I = '0;
  endtask

  task automatic wr(input string tag, input logic [31:0] adr, input logic [31:0] dat);
    logic a, e;
    logic [31:0] d;
    bus(1'b1, adr, dat, a, e, d);
    chk({tag, "_ack"}, {31'd0, a}, 32'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic a, e;
    logic [31:0] d;
    bus(1'b0, adr, 32'd0, a, e, d);
    chk(tag, d, exp);
  endtask

  task automatic record(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      sample_cycle();
    end
  endtask

  // Run until n frames have ended and the line is idle again, or the budget expires.
  task automatic collect(input int n);
    timed_out = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      sample_cycle();
      if (obs_eot.size() >= n && !valid_o) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic compare(input string tag);
    int nmis;
    int n;
    nmis = 0;
    chk({tag, "_timeout"}, {31'd0, timed_out}, 32'd0);
    chk({tag, "_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) nmis++;
    chk({tag, "_bits"}, 32'(nmis), 32'd0);
    chk({tag, "_runs"}, 32'(runs), 32'd1);
    chk({tag, "_neot"}, 32'(obs_eot.size()), 32'(exp_eot.size()));
    for (int i = 0; i < exp_eot.size() && i < obs_eot.size(); i++)
      chk({tag, "_eotpos"}, 32'(obs_eot[i]), 32'(exp_eot[i]));
    chk({tag, "_idle_data"}, {31'd0, data_o}, {31'd0, IDLE});
    chk({tag, "_idle_valid"}, {31'd0, valid_o}, 32'd0);
    exp_q.delete();
    exp_eot.delete();
  endtask

  initial begin
    logic a, e;
    logic [31:0] d;
    logic [FW-1:0] f [5];
    int div;
    bit msb;
    int nf;

    repeat (3) @(posedge clk);
    @(negedge clk);
    RST_I = 1'b0;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_eot", {31'd0, eot_o}, 32'd0);
    chk("rst_data", {31'd0, data_o}, {31'd0, IDLE});
    rd_chk("rst_status", 32'h8, 32'h2);
    rd_chk("rst_ctrl", 32'h4, 32'h0);

    // CTRL readback: FLUSH reads as 0.
    wr("ctrl_w", 32'h4, 32'h0002_0007);
    rd_chk("ctrl_rb", 32'h4, 32'h0002_0003);

    // Test 1: MSB-first, DIV=0, fixed frame.
    wr("t1_ctrl", 32'h4, 32'h0000_0003);
    clear_obs();
    f[0] = {9'h07C, 9'h0A5, 9'h1BC};
    model_frame(f[0], 0, 1'b1);
    wr("t1_tx", 32'h0, {5'd0, f[0]});
    rd_chk("t1_lvl1", 32'h8, 32'h0000_0100);
    collect(1);
    compare("t1");
    rd_chk("t1_lvl0", 32'h8, 32'h2);

    // Test 2: LSB-first, DIV=3, single 1 bit.
    wr("t2_ctrl", 32'h4, 32'h0003_0001);
    clear_obs();
    model_frame(27'd1, 3, 1'b0);
    wr("t2_tx", 32'h0, 32'h1);
    collect(1);
    compare("t2");

    // Test 3: overflow with EN=0.
    wr("t3_ctrl", 32'h4, 32'h0);
    for (int i = 0; i < 5; i++) begin
      f[i] = 27'($urandom);
      bus(1'b1, 32'h0, {5'd0, f[i]}, a, e, d);
      chk("t3_ack", {31'd0, a}, (i < 4) ? 32'd1 : 32'd0);
      chk("t3_err", {31'd0, e}, (i < 4) ? 32'd0 : 32'd1);
    end
    rd_chk("t3_stat_full", 32'h8, 32'h0000_040C);
    wr("t3_clr", 32'h8, 32'h8);
    rd_chk("t3_stat_clr", 32'h8, 32'h0000_0404);

    // Flush the queue, then Test 4: 3 frames back-to-back at DIV=0.
    wr("t4_flush", 32'h4, 32'h4);
    rd_chk("t4_empty", 32'h8, 32'h2);
    msb = 1'($urandom);
    clear_obs();
    for (int i = 0; i < 3; i++) begin
      f[i] = 27'($urandom);
      model_frame(f[i], 0, msb);
      wr("t4_tx", 32'h0, {5'd0, f[i]});
    end
    wr("t4_ctrl", 32'h4, {30'd0, msb, 1'b1});
    collect(3);
    compare("t4");

    // Randomized frames, divider and bit order.
    for (int it = 0; it < 4; it++) begin
      wr("rnd_off", 32'h4, 32'h0);
      nf  = $urandom_range(1, 3);
      div = $urandom_range(0, 3);
      msb = 1'($urandom);
      clear_obs();
      for (int i = 0; i < nf; i++) begin
        f[i] = 27'($urandom);
        model_frame(f[i], div, msb);
        wr("rnd_tx", 32'h0, {5'd0, f[i]});
      end
      wr("rnd_ctrl", 32'h4, {14'd0, 2'(div), 14'd0, msb, 1'b1});
      collect(nf);
      compare("rnd");
    end

    // Test 5a: FLUSH mid-frame; current frame completes.
    wr("t5_off", 32'h4, 32'h0);
    clear_obs();
    for (int i = 0; i < 3; i++) begin
      f[i] = 27'($urandom);
      wr("t5_tx", 32'h0, {5'd0, f[i]});
    end
    model_frame(f[0], 1, 1'b0);
    wr("t5_en", 32'h4, 32'h0001_0001);
    record(10);
    wr("t5_flush", 32'h4, 32'h0001_0005);
    rd_chk("t5_stat_busy", 32'h8, 32'h3);
    collect(1);
    compare("t5");
    rd_chk("t5_stat_end", 32'h8, 32'h2);

    // Test 5b: reset mid-frame.
    wr("t5r_off", 32'h4, 32'h0);
    for (int i = 0; i < 2; i++) wr("t5r_tx", 32'h0, $urandom);
    wr("t5r_en", 32'h4, 32'h1);
    record(5);
    chk("t5r_inflight", {31'd0, valid_o}, 32'd1);
    @(negedge clk);
    RST_I = 1'b1;
    @(posedge clk);
    #1;
    chk("t5r_valid", {31'd0, valid_o}, 32'd0);
    chk("t5r_data", {31'd0, data_o}, {31'd0, IDLE});
    chk("t5r_eot", {31'd0, eot_o}, 32'd0);
    @(negedge clk);
    RST_I = 1'b0;
    rd_chk("t5r_stat", 32'h8, 32'h2);
    rd_chk("t5r_ctrl", 32'h4, 32'h0);

    // Test 6: unmapped read and TXDATA read.
    bus(1'b0, 32'hC, 32'h0, a, e, d);
    chk("t6_unm_err", {31'd0, e}, 32'd1);
    chk("t6_unm_ack", {31'd0, a}, 32'd0);
    chk("t6_unm_dat", d, 32'h0);
    bus(1'b0, 32'h0, 32'h0, a, e, d);
    chk("t6_tx_err", {31'd0, e}, 32'd1);
    chk("t6_tx_ack", {31'd0, a}, 32'd0);
    chk("t6_tx_dat", d, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
